// File: rtl/input_fifo_pkg.sv
// rtl/input_fifo_pkg.sv - shared defaults and sizing helper for the operand input FIFO.
package input_fifo_pkg;

  localparam int INPUT_FIFO_WIDTH = 8;
  localparam int INPUT_FIFO_DEPTH = 4;

  // Occupancy needs one bit more than the pointer so that it can represent DEPTH.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// rtl/fifo_wrap_ptr.sv - wrapping FIFO pointer with synchronous clear.
module fifo_wrap_ptr #(
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              clr,
  output logic [ADDR_W-1:0] ptr
);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  // Depth is a power of two, so natural overflow gives the DEPTH-1 -> 0 wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/input_fifo_register.sv
// rtl/input_fifo_register.sv - DEPTH-entry operand FIFO with flush and sticky overflow.
// Define INPUT_FIFO_BYPASS_EN for a zero-latency empty-queue bypass path.
module input_fifo_register
  import input_fifo_pkg::*;
#(
  parameter int WIDTH = INPUT_FIFO_WIDTH,
  parameter int DEPTH = INPUT_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      flush,
  input  logic                      clear_ovf,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              ovf_q;
  logic              ovf_d;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              empty;
  logic              push;
  logic              pop;
  logic              byp_take;
  logic              wr_inc;
  logic              rd_inc;

  assign empty    = (count_q == '0);
  assign in_ready = (count_q != FULL_CNT);
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

`ifdef INPUT_FIFO_BYPASS_EN
  assign out_valid = ~empty | in_valid;
  assign out_data  = !empty ? mem_q[rd_ptr] : (in_valid ? in_data : '0);
  // A word handed straight through while empty never touches storage.
  assign byp_take  = empty & in_valid & out_ready;
`else
  assign out_valid = ~empty;
  assign out_data  = out_valid ? mem_q[rd_ptr] : '0;
  assign byp_take  = 1'b0;
`endif

  assign wr_inc = push & ~byp_take & ~flush;
  assign rd_inc = pop & ~byp_take & ~flush;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(wr_inc) - CNT_W'(rd_inc);
    end
  end

  // Set beats clear so an attempt in the clearing cycle is not lost.
  assign ovf_d = (in_valid & ~in_ready) | (ovf_q & ~clear_ovf);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && wr_inc) begin
      mem_q[wr_ptr] <= in_data;
    end
  end

  fifo_wrap_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (wr_inc),
    .clr   (flush),
    .ptr   (wr_ptr)
  );

  fifo_wrap_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_inc),
    .clr   (flush),
    .ptr   (rd_ptr)
  );

  assign count    = count_q;
  assign overflow = ovf_q;

endmodule
